// File: rtl/fpu_addsub_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fpu_addsub_pkg                                             |
// | Description : Shared types and constants for the add/sub issuer: FSM     |
// |               state enum, op encodings, operand/tag widths and the       |
// |               queued command record.                                     |
// | Macro       : FPU_ADDSUB_ACCUM_EN adds the acc bit to the command record |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package fpu_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int OPND_W = 64;
  localparam int TAG_W  = 4;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic              op;
    logic [TAG_W-1:0]  tag;
`ifdef FPU_ADDSUB_ACCUM_EN
    logic              acc;
`endif
  } cmd_t;

endpackage
`default_nettype wire

// File: rtl/fpu_cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fpu_cmd_fifo                                               |
// | Description : Synchronous command FIFO. The output word is a register    |
// |               loaded only on a pop, so it stays stable until the next    |
// |               pop and can drive the FPU operands directly.               |
// | Ports       : clk, rst       clock / synchronous active-high reset       |
// |               push_i, din_i  write (ignored when full)                   |
// |               pop_i, dout_o  read into the output register (ignored when |
// |                              empty)                                      |
// |               full_o, empty_o occupancy flags                            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module fpu_cmd_fifo
  import fpu_addsub_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  cmd_t din_i,
  output cmd_t dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(DEPTH);

  cmd_t                 mem_q [DEPTH];
  cmd_t                 dout_q;
  logic [c_ptr_w-1:0]   wr_ptr_q;
  logic [c_ptr_w-1:0]   rd_ptr_q;
  logic [c_ptr_w:0]     count_q;
  logic                 w_push;
  logic                 w_pop;

  assign full_o  = (count_q == c_depth);
  assign empty_o = (count_q == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign dout_o  = dout_q;

  // Storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= din_i;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop) begin
        dout_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_addsub_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fpu_addsub_issuer                                          |
// | Description : Sequential front end for the combinational Add_Sub unit.   |
// |               Queues commands, presents one at a time to the unit,       |
// |               captures result/exception on fpu_done_i (or forces a       |
// |               timeout completion) and returns it with the echoed tag.    |
// | Ports       : cmd_*_i / cmd_ready_o   command valid/ready stream         |
// |               rsp_*_o / rsp_ready_i   response valid/ready stream        |
// |               fpu_a_o/fpu_b_o/fpu_op_o operands to the unit               |
// |               fpu_result_i/fpu_exception_i/fpu_done_i from the unit      |
// |               busy_o                  FSM active or commands queued      |
// | Macro       : FPU_ADDSUB_ACCUM_EN - adds cmd_acc_i and an accumulator    |
// |               that can replace operand A.                                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module fpu_addsub_issuer
  import fpu_addsub_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [OPND_W-1:0] cmd_a_i,
  input  logic [OPND_W-1:0] cmd_b_i,
  input  logic              cmd_op_i,
  input  logic [TAG_W-1:0]  cmd_tag_i,
`ifdef FPU_ADDSUB_ACCUM_EN
  input  logic              cmd_acc_i,
`endif
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [OPND_W-1:0] rsp_result_o,
  output logic              rsp_exception_o,
  output logic              rsp_timeout_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic [OPND_W-1:0] fpu_a_o,
  output logic [OPND_W-1:0] fpu_b_o,
  output logic              fpu_op_o,
  input  logic [OPND_W-1:0] fpu_result_i,
  input  logic              fpu_exception_i,
  input  logic              fpu_done_i,
  output logic              busy_o
);

  localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q;
  logic                rsp_valid_q;
  logic [OPND_W-1:0]   rsp_result_q;
  logic                rsp_exception_q;
  logic                rsp_timeout_q;
  logic [TAG_W-1:0]    rsp_tag_q;

  cmd_t w_cmd_in;
  cmd_t w_cmd_cur;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_cap_done;
  logic w_cap_to;
  logic w_rsp_clr;

  always_comb begin
    w_cmd_in     = '0;
    w_cmd_in.a   = cmd_a_i;
    w_cmd_in.b   = cmd_b_i;
    w_cmd_in.op  = cmd_op_i;
    w_cmd_in.tag = cmd_tag_i;
`ifdef FPU_ADDSUB_ACCUM_EN
    w_cmd_in.acc = cmd_acc_i;
`endif
  end

  // The FIFO output register doubles as the operand register: it is loaded
  // on the pop edge and is stable for the whole ISSUE/HOLD of that command.
  fpu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid_i),
    .pop_i   (w_pop),
    .din_i   (w_cmd_in),
    .dout_o  (w_cmd_cur),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign cmd_ready_o     = !w_full;
  assign busy_o          = (state_q != IDLE) || !w_empty;
  assign fpu_b_o         = w_cmd_cur.b;
  assign fpu_op_o        = w_cmd_cur.op;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_result_o    = rsp_result_q;
  assign rsp_exception_o = rsp_exception_q;
  assign rsp_timeout_o   = rsp_timeout_q;
  assign rsp_tag_o       = rsp_tag_q;

`ifdef FPU_ADDSUB_ACCUM_EN
  logic [OPND_W-1:0] acc_q;

  // The accumulator only changes on a capture edge, which also leaves ISSUE,
  // so operand A stays constant while the unit is evaluating.
  assign fpu_a_o = w_cmd_cur.acc ? acc_q : w_cmd_cur.a;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (w_cap_done && !fpu_exception_i) begin
      acc_q <= fpu_result_i;
    end
  end
`else
  assign fpu_a_o = w_cmd_cur.a;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    w_pop      = 1'b0;
    w_cap_done = 1'b0;
    w_cap_to   = 1'b0;
    w_rsp_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (fpu_done_i) begin
          w_cap_done = 1'b1;
          state_d    = HOLD;
        end else if (cnt_q == c_timeout_last) begin
          w_cap_to = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        // rsp_valid is always set in HOLD, so rsp_ready alone is the handshake.
        if (rsp_ready_i) begin
          w_rsp_clr = 1'b1;
          if (!w_empty) begin
            w_pop   = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q           <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_result_q    <= '0;
      rsp_exception_q <= 1'b0;
      rsp_timeout_q   <= 1'b0;
      rsp_tag_q       <= '0;
    end else begin
      if (w_pop)                 cnt_q <= '0;
      else if (state_q == ISSUE) cnt_q <= cnt_q + 1'b1;

      if (w_cap_done) begin
        rsp_valid_q     <= 1'b1;
        rsp_result_q    <= fpu_result_i;
        rsp_exception_q <= fpu_exception_i;
        rsp_timeout_q   <= 1'b0;
        rsp_tag_q       <= w_cmd_cur.tag;
      end else if (w_cap_to) begin
        rsp_valid_q     <= 1'b1;
        rsp_result_q    <= '0;
        rsp_exception_q <= 1'b1;
        rsp_timeout_q   <= 1'b1;
        rsp_tag_q       <= w_cmd_cur.tag;
      end else if (w_rsp_clr) begin
        rsp_valid_q     <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fpu_addsub_issuer                                       |
// | Description : Self-checking bench for fpu_addsub_issuer. Provides a      |
// |               behavioural Add_Sub stub built on real arithmetic, a       |
// |               directed vector table, timeout/reset, backpressure,        |
// |               randomized traffic and (with FPU_ADDSUB_ACCUM_EN) an       |
// |               accumulate chain.                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_fpu_addsub_issuer;
  import fpu_addsub_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [63:0] cmd_a, cmd_b;
  logic [3:0]  cmd_tag;
`ifdef FPU_ADDSUB_ACCUM_EN
  logic        cmd_acc;
`endif
  logic        rsp_valid, rsp_ready, rsp_exception, rsp_timeout;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic [63:0] fpu_a, fpu_b, fpu_result;
  logic        fpu_op, fpu_exception, fpu_done, busy;
  logic        done_en;
  logic [64:0] fpu_out;

  always #5 clk = ~clk;

  fpu_addsub_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_op_i(cmd_op), .cmd_tag_i(cmd_tag),
`ifdef FPU_ADDSUB_ACCUM_EN
    .cmd_acc_i(cmd_acc),
`endif
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_exception_o(rsp_exception),
    .rsp_timeout_o(rsp_timeout), .rsp_tag_o(rsp_tag),
    .fpu_a_o(fpu_a), .fpu_b_o(fpu_b), .fpu_op_o(fpu_op),
    .fpu_result_i(fpu_result), .fpu_exception_i(fpu_exception),
    .fpu_done_i(fpu_done), .busy_o(busy)
  );

  // ---------------- behavioural Add_Sub unit ----------------
  function automatic logic [63:0] sp2dp(input logic [31:0] s);
    if (s[30:0] == 31'd0) return {s[31], 63'd0};
    return {s[31], 11'({3'd0, s[30:23]} + 11'd896), s[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] dp2sp(input logic [63:0] d);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Returns {exception, result}; single precision when both upper words are 0.
  function automatic logic [64:0] fpu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic op);
    real ra, rb, rr;
    if (a[63:32] == 32'd0 && b[63:32] == 32'd0) begin
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {1'b1, 64'd0};
      ra = $bitstoreal(sp2dp(a[31:0]));
      rb = $bitstoreal(sp2dp(b[31:0]));
      rr = op ? ra - rb : ra + rb;
      return {1'b0, 32'd0, dp2sp($realtobits(rr))};
    end
    if (a[62:52] == 11'h7FF || b[62:52] == 11'h7FF) return {1'b1, 64'd0};
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    rr = op ? ra - rb : ra + rb;
    return {1'b0, $realtobits(rr)};
  endfunction

  always_comb fpu_out = fpu_model(fpu_a, fpu_b, fpu_op);
  assign fpu_result    = fpu_out[63:0];
  assign fpu_exception = fpu_out[64];
  assign fpu_done      = done_en;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] gen_opnd(input bit dbl);
    logic [7:0]  e8;
    logic [10:0] e11;
    if (!dbl) begin
      e8 = 8'(110 + $urandom_range(0, 30));
      if ($urandom_range(0, 15) == 0) e8 = 8'hFF;
      return {32'd0, 1'($urandom), e8, 23'($urandom)};
    end
    e11 = 11'(1000 + $urandom_range(0, 50));
    if ($urandom_range(0, 15) == 0) e11 = 11'h7FF;
    return {1'($urandom), e11, 20'($urandom), 32'($urandom)};
  endfunction

  // Scoreboard: expected responses in acceptance order.
  typedef struct {
    logic [63:0] res;
    logic        exc;
    logic [3:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [64:0] mon_m;
  logic        mon_en = 1'b0;
  bit          prev_hold = 1'b0;
  logic [63:0] prev_res;
  logic        prev_exc;
  logic [3:0]  prev_tag;
  int          rsp_cnt = 0;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (cmd_valid && cmd_ready) begin
        mon_m = fpu_model(cmd_a, cmd_b, cmd_op);
        exp_q.push_back('{res: mon_m[63:0], exc: mon_m[64], tag: cmd_tag});
      end
      if (prev_hold) begin
        chk("hold_valid", rsp_valid, 1'b1);
        chk("hold_result", rsp_result, prev_res);
        chk("hold_exception", rsp_exception, prev_exc);
        chk("hold_tag", rsp_tag, prev_tag);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got tag %h expected no response", rsp_tag);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_result", rsp_result, mon_e.res);
          chk("sb_exception", rsp_exception, mon_e.exc);
          chk("sb_timeout", rsp_timeout, 1'b0);
          chk("sb_tag", rsp_tag, mon_e.tag);
          rsp_cnt++;
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_res  = rsp_result;
      prev_exc  = rsp_exception;
      prev_tag  = rsp_tag;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        op;
    logic [3:0]  tag;
    logic [63:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    int seen;
    vecs[0] = '{64'h3FC00000,          64'h40200000,          OP_ADD, 4'd3,  64'h40800000,          1'b0};
    vecs[1] = '{64'h3FF0000000000000, 64'h3FE0000000000000, OP_SUB, 4'd5,  64'h3FE0000000000000, 1'b0};
    vecs[2] = '{64'h7F800000,          64'h3F800000,          OP_ADD, 4'd7,  64'h0,                 1'b1};
    vecs[3] = '{64'h40400000,          64'h3F800000,          OP_SUB, 4'd1,  64'h40000000,          1'b0};
    vecs[4] = '{64'h3F800000,          64'h40000000,          OP_SUB, 4'd2,  64'hBF800000,          1'b0};
    vecs[5] = '{64'h3FF0000000000000, 64'h3FF0000000000000, OP_ADD, 4'hE,  64'h4000000000000000, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = 1'b0; cmd_tag = '0;
`ifdef FPU_ADDSUB_ACCUM_EN
    cmd_acc = 1'b0;
`endif
    rsp_ready = 1'b0; done_en = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    chk("rst_rsp_exception", rsp_exception, 1'b0);
    chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk("rst_rsp_tag", rsp_tag, 4'd0);
    chk("rst_fpu_a", fpu_a, 64'd0);
    chk("rst_fpu_b", fpu_b, 64'd0);
    chk("rst_fpu_op", fpu_op, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Table: each command alone, checking the 2-cycle accept-to-response latency.
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_a = vecs[i].a; cmd_b = vecs[i].b;
      cmd_op = vecs[i].op; cmd_tag = vecs[i].tag;
      @(negedge clk);
      chk("vec_cmd_ready", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("vec_lat_t1", rsp_valid, 1'b0);
      tick();
      @(negedge clk);
      chk("vec_lat_t2", rsp_valid, 1'b0);
      tick();
      @(negedge clk);
      chk("vec_rsp_valid", rsp_valid, 1'b1);
      chk("vec_result", rsp_result, vecs[i].res);
      chk("vec_exception", rsp_exception, vecs[i].exc);
      chk("vec_timeout", rsp_timeout, 1'b0);
      chk("vec_tag", rsp_tag, vecs[i].tag);
      tick();
      @(negedge clk);
      chk("vec_after_valid", rsp_valid, 1'b0);
      chk("vec_after_busy", busy, 1'b0);
      tick();
    end

    // Timeout: the unit never signals done.
    done_en = 1'b0;
    cmd_valid = 1'b1; cmd_a = 64'h3F800000; cmd_b = 64'h3F800000; cmd_op = OP_ADD; cmd_tag = 4'd9;
    tick();
    cmd_valid = 1'b0;
    waited = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
      tick();
      waited++;
    end
    // One cycle to pop, then TIMEOUT cycles in ISSUE.
    chk("to_latency", waited, TIMEOUT + 1);
    chk("to_valid", rsp_valid, 1'b1);
    chk("to_result", rsp_result, 64'd0);
    chk("to_exception", rsp_exception, 1'b1);
    chk("to_timeout", rsp_timeout, 1'b1);
    chk("to_tag", rsp_tag, 4'd9);
    tick();

    // Reset while a command is in ISSUE and another is queued.
    cmd_valid = 1'b1; cmd_tag = 4'd10;
    tick();
    cmd_tag = 4'd11;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_valid", rsp_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    done_en = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("midrst_no_stale", seen, 0);
    tick();

    // Backpressure: 6 offered with rsp_ready low, DEPTH+1 accepted.
    exp_q.delete();
    rsp_cnt = 0;
    rsp_ready = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_a = gen_opnd(1'b0); cmd_b = gen_opnd(1'b0);
      cmd_op = 1'($urandom); cmd_tag = 4'(i);
      @(negedge clk);
      if (i < 5) chk("bp_ready", cmd_ready, 1'b1);
      else       chk("bp_full_ready", cmd_ready, 1'b0);
      tick();
    end
    cmd_valid = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 80 && rsp_cnt < 5; k++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    rsp_ready = 1'b0;
    chk("bp_rsp_count", rsp_cnt, 5);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Randomized traffic against the scoreboard.
    rsp_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      bit dbl;
      dbl = 1'($urandom);
      cmd_valid = 1'($urandom);
      cmd_a = gen_opnd(dbl); cmd_b = gen_opnd(dbl);
      cmd_op = 1'($urandom); cmd_tag = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 60 && (exp_q.size() != 0 || rsp_valid); k++) tick();
    chk("rand_drain_empty", exp_q.size(), 0);
    chk("rand_some_rsp", (rsp_cnt > 20), 1'b1);
    @(negedge clk);
    chk("rand_end_busy", busy, 1'b0);
    mon_en = 1'b0;
    tick();

`ifdef FPU_ADDSUB_ACCUM_EN
    begin
      logic [63:0] acc_exp [3];
      int got;
      acc_exp[0] = 64'h40000000;
      acc_exp[1] = 64'h40400000;
      acc_exp[2] = 64'h40800000;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        cmd_valid = 1'b1; cmd_a = 64'h3F800000; cmd_b = 64'h3F800000;
        cmd_op = OP_ADD; cmd_tag = 4'(i + 1); cmd_acc = (i != 0);
        tick();
      end
      cmd_valid = 1'b0; cmd_acc = 1'b0;
      rsp_ready = 1'b1;
      got = 0;
      for (int k = 0; k < 40 && got < 3; k++) begin
        @(negedge clk);
        if (rsp_valid) begin
          chk("acc_result", rsp_result, acc_exp[got]);
          chk("acc_tag", rsp_tag, 4'(got + 1));
          got++;
        end
        tick();
      end
      chk("acc_count", got, 3);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_addsub_issuer.md
# fpu_addsub_issuer

Sequential front end that drives the combinational floating-point add/sub unit (`Add_Sub`). It sits between a command producer and that unit. Commands arrive over a valid/ready stream and are queued in a small FIFO. The issuer presents one command's operands to the unit, captures `result`/`exception` when `done` is seen, and returns them on a valid/ready response stream with an echoed tag. Precision is implicit in the operands, as the unit itself decides: both upper words zero means single, otherwise double.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- TIMEOUT, 8, cycles to wait for `fpu_done` before forcing a timeout completion; ≥1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_a  in  64  operand A (single in [31:0] with [63:32]=0, or double)
- cmd_b  in  64  operand B
- cmd_op  in  1  0=add, 1=sub
- cmd_tag  in  4  opaque tag, echoed on response
- cmd_acc  in  1  present only with FPU_ADDSUB_ACCUM_EN; replace A with accumulator
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_result  out  64  captured result
- rsp_exception  out  1  unit exception or timeout
- rsp_timeout  out  1  completion forced by timeout
- rsp_tag  out  4  echoed tag
- fpu_a, fpu_b  out  64  operands to unit (registered)
- fpu_op  out  1  `add_sub_choose` to unit (registered)
- fpu_result  in  64;  fpu_exception  in  1;  fpu_done  in  1  from unit
- busy  out  1  state≠IDLE or FIFO non-empty

## Operation
- FIFO push on cmd_valid&cmd_ready. cmd_ready=!full, with no bypass. A push is allowed in the same cycle as a pop even when full only if not full at cycle start.
- FSM states are IDLE, ISSUE and HOLD.
- IDLE: if FIFO non-empty, pop and load fpu_a/fpu_b/fpu_op/tag registers, clear the timeout counter, and go to ISSUE.
- ISSUE: the operands are stable. The counter increments each cycle.
  - If fpu_done=1, capture rsp_result=fpu_result, rsp_exception=fpu_exception and rsp_timeout=0. Set rsp_valid and go to HOLD.
  - Otherwise, if the counter reaches TIMEOUT-1, capture rsp_result=0, rsp_exception=1 and rsp_timeout=1. Set rsp_valid and go to HOLD.
- HOLD: the response is held stable while rsp_valid&!rsp_ready. On rsp_valid&rsp_ready:
  - If the FIFO is non-empty, pop the next command in the same cycle and go to ISSUE.
  - Otherwise clear rsp_valid and go to IDLE.
- Operands pass through unmodified. The issuer does no precision conversion.
- Reset mid-operation discards the FIFO contents and any in-flight command. No response is produced for them.

## Timing
- Reset values:
  - cmd_ready=1, rsp_valid=0, busy=0.
  - rsp_result=0, rsp_exception=0, rsp_timeout=0, rsp_tag=0.
  - fpu_a=0, fpu_b=0, fpu_op=0.
  - FSM=IDLE, FIFO empty, accumulator=0.
- Latency: a command accepted at edge t into an idle block is popped at edge t+1, captured at edge t+2, and rsp_valid is high in cycle t+2→t+3, i.e. 2 cycles after accept.
- Throughput with rsp_ready=1 and the FIFO pre-filled: one response per 2 cycles (ISSUE, HOLD).
- Timeout path: rsp_valid rises TIMEOUT cycles after entering ISSUE.
- Occupancy limit: the maximum accepted but unanswered count is DEPTH+1 (one in ISSUE/HOLD plus DEPTH queued).

## Configuration
- FPU_ADDSUB_ACCUM_EN defined:
  - The cmd_acc bit is stored in the FIFO.
  - A 64-bit accumulator register loads rsp_result on every non-exception capture.
  - On pop with cmd_acc=1, fpu_a=accumulator instead of cmd_a.
  - An exception capture leaves the accumulator unchanged.
- Not defined: no cmd_acc port, no accumulator register, and fpu_a is always cmd_a.

## Structure
- Package fpu_addsub_pkg holds:
  - the state enum (IDLE, ISSUE, HOLD);
  - op encodings OP_ADD=0, OP_SUB=1;
  - the operand width 64 and the tag width 4;
  - the command struct {a, b, op, tag[, acc]}.
- Sub-module fpu_cmd_fifo: synchronous FIFO, parameter DEPTH, ports push/pop/full/empty/din/dout, with a registered output read on pop. The issuer instantiates one.

## Test plan
- Single add: a=0x3FC00000, b=0x40200000, op=0, tag=3 → rsp_result=0x0000000040800000, exception=0, rsp_tag=3, 2 cycles after accept.
- Double sub: a=0x3FF0000000000000, b=0x3FE0000000000000, op=1 → rsp_result=0x3FE0000000000000.
- Exception: a=0x7F800000, b=0x3F800000, add → rsp_result=0, rsp_exception=1, rsp_timeout=0.
- Backpressure: rsp_ready=0, push 6 commands with DEPTH=4 → 5 accepted, cmd_ready low on the 6th. Then release rsp_ready → 5 responses in tag order, with the result stable throughout each HOLD.
- Timeout: stub fpu_done=0, TIMEOUT=8 → response 8 cycles after ISSUE with rsp_exception=1, rsp_timeout=1, rsp_result=0. Assert rst during a later ISSUE → rsp_valid=0 next cycle and no stale response.
- Accumulate (FPU_ADDSUB_ACCUM_EN): first a=0x3F800000+0x3F800000; then two acc=1 adds of b=0x3F800000 → responses 0x40000000, 0x40400000, 0x40800000.
